probe_phase_sweeper: RTL
========================

Name: probe_phase_sweeper

Overview:
Sequencer that sits upstream of the probe detector. It steps the fine phase of shifting_clk through the MMCM dynamic phase-shift port and requests one averaged hit-count measurement per phase step. Each returned count is stored in a per-step result RAM. It then locates the first step where the count crosses AVER_TIME/2, which marks the probe signal's transition edge, so software can read back the full sampling profile.

Parameters:
NUM_STEPS, 448, number of phase points measured; at most 2**STEP_W.
STEP_W, 9, width of step index and RAM address.
COUNT_WIDTH, 14, width of a measurement count.
AVER_TIME, 10000, trials per measurement; threshold = AVER_TIME>>1.
SETTLE_CYCLES, 16, idle cycles after ps_done before measuring; must be >= 1.
TIMEOUT, 65535, maximum cycles to wait for ps_done or meas_valid.

Ports:
system_clk  in  1  sole clock.
system_rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse that begins a sweep; ignored while busy.
busy  out  1  high from the cycle after accepted start until done.
done  out  1  one-cycle pulse at sweep end, normal or error.
error  out  1  sticky; set on timeout, cleared by next accepted start.
ps_en  out  1  one-cycle phase-shift request to MMCM.
ps_incdec  out  1  phase direction; tied to 1 (increment).
ps_done  in  1  MMCM acknowledge, one-cycle pulse.
meas_start  out  1  one-cycle request to detector.
meas_valid  in  1  one-cycle pulse; meas_count valid this cycle.
meas_count  in  COUNT_WIDTH  hit count for current step.
rd_addr  in  STEP_W  result RAM read address.
rd_data  out  COUNT_WIDTH  RAM data, registered.
edge_found  out  1  a threshold crossing was detected during the last sweep.
edge_step  out  STEP_W  index of the first crossing step.
edge_dir  out  1  1 = rising (low to high count), 0 = falling.

Behaviour:
- Reset: every output 0, state IDLE, step index 0, timeout counter 0. Reset mid-sweep aborts immediately. The MMCM phase is not restored; software resets the MMCM.
- FSM states: IDLE, MEAS, WAIT_M, STORE, SHIFT, WAIT_PS, SETTLE, FIN.
- IDLE: when start=1, clear error, edge_found, edge_step, edge_dir and the step index, then go to MEAS. busy is 1 from the next cycle.
- MEAS: meas_start=1 for one cycle, clear the timeout counter, go to WAIT_M.
- WAIT_M: on meas_valid, capture meas_count and go to STORE. If the timeout counter reaches TIMEOUT, set error and go to FIN.
- STORE: write the captured count to RAM[step]. Then apply edge detection:
  - if step>0 and edge_found=0, compare (prev>=thr) with (cur>=thr); a count equal to thr counts as high.
  - if they differ: edge_found=1, edge_step=step, edge_dir=cur>=thr.
  - update prev=cur.
  - if step==NUM_STEPS-1 go to FIN, else go to SHIFT.
- SHIFT: ps_en=1 for exactly one cycle, ps_incdec=1, step increments, go to WAIT_PS.
- WAIT_PS: wait for ps_done; the timeout rule is the same as in WAIT_M. On ps_done, load the settle counter and go to SETTLE.
- SETTLE: count down SETTLE_CYCLES cycles, then go to MEAS.
- FIN: done=1 for one cycle, busy=0 on the same edge, go to IDLE.
- Sweep totals: exactly NUM_STEPS measurements and NUM_STEPS-1 ps_en pulses. Step 0 is measured at the unshifted phase.
- Spurious inputs: ps_done outside WAIT_PS and meas_valid outside WAIT_M are ignored. A start arriving while busy is ignored.
- Edge detection records only the first crossing; later crossings are ignored.
- RAM: simple dual-port, NUM_STEPS x COUNT_WIDTH. rd_data = RAM[rd_addr] one cycle after rd_addr is presented. Reads are allowed during a sweep. A read of the same address in the write cycle returns the old data.
- Arithmetic: thr is a COUNT_WIDTH-bit constant. Comparisons are unsigned. The step index never wraps, since the sweep ends at NUM_STEPS-1.

Test Plan:
- NUM_STEPS=8, AVER_TIME=100, SETTLE_CYCLES=2; detector model returns 0,0,10,40,60,100,100,100 -> 7 ps_en pulses, 8 meas_start pulses, RAM[0..7] match, edge_found=1, edge_step=4, edge_dir=1, one done pulse, error=0.
- Counts 100,100,30,0,0,0,0,50 -> edge_step=2, edge_dir=0, and the later crossing at step 7 is ignored.
- Counts 49,49,...,49 then 50 at step 7 -> edge_step=7, rising (equality counts as high); all counts 20 -> edge_found=0.
- ps_done withheld after the first ps_en, TIMEOUT=100 -> error=1 and done 100 cycles after entering WAIT_PS. Next start clears error and a normal sweep completes.
- start pulsed while busy, and spurious ps_done/meas_valid injected in SETTLE -> no extra ps_en or meas_start pulses, same results as the first scenario.
- system_rst asserted during WAIT_PS at step 3 -> next cycle all outputs 0, busy=0. A new start re-sweeps from step 0 and the RAM is overwritten.

Source files
------------

// File: rtl/probe_phase_sweeper.sv
// probe_phase_sweeper: steps MMCM fine phase, collects one averaged count per step, locates the threshold crossing.
module probe_phase_sweeper #(
    parameter int NUM_STEPS     = 448,
    parameter int STEP_W        = 9,
    parameter int COUNT_WIDTH   = 14,
    parameter int AVER_TIME     = 10000,
    parameter int SETTLE_CYCLES = 16,
    parameter int TIMEOUT       = 65535
) (
    input  logic                   system_clk,
    input  logic                   system_rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   ps_en,
    output logic                   ps_incdec,
    input  logic                   ps_done,
    output logic                   meas_start,
    input  logic                   meas_valid,
    input  logic [COUNT_WIDTH-1:0] meas_count,
    input  logic [STEP_W-1:0]      rd_addr,
    output logic [COUNT_WIDTH-1:0] rd_data,
    output logic                   edge_found,
    output logic [STEP_W-1:0]      edge_step,
    output logic                   edge_dir
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] THR = COUNT_WIDTH'(AVER_TIME >> 1);

    typedef enum logic [2:0] {IDLE, MEAS, WAIT_M, STORE, SHIFT, WAIT_PS, SETTLE, FIN} state_t;

    state_t                 state_q, state_d;
    logic [STEP_W-1:0]      step_q, step_d, edge_step_q, edge_step_d;
    logic [TW-1:0]          tmo_q, tmo_d, tmo_inc;
    logic [SW-1:0]          settle_q, settle_d;
    logic [COUNT_WIDTH-1:0] cur_q, cur_d, prev_q, prev_d, rd_data_q;
    logic                   busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                   ps_en_q, ps_en_d, meas_start_q, meas_start_d;
    logic                   edge_found_q, edge_found_d, edge_dir_q, edge_dir_d, tmo_hit;
    logic [COUNT_WIDTH-1:0] mem [NUM_STEPS];

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        tmo_inc      = tmo_q + 1'b1;
        tmo_hit      = tmo_inc == TW'(TIMEOUT);
        tmo_d        = '0;
        settle_d     = settle_q;
        cur_d        = cur_q;
        prev_d       = prev_q;
        error_d      = error_q;
        edge_found_d = edge_found_q;
        edge_step_d  = edge_step_q;
        edge_dir_d   = edge_dir_q;
        case (state_q)
            IDLE: if (start) begin
                state_d      = MEAS;
                step_d       = '0;
                error_d      = 1'b0;
                edge_found_d = 1'b0;
                edge_step_d  = '0;
                edge_dir_d   = 1'b0;
            end
            MEAS: state_d = WAIT_M;
            WAIT_M: if (meas_valid) begin
                cur_d   = meas_count;
                state_d = STORE;
            end else begin
                tmo_d   = tmo_inc;
                error_d = error_q | tmo_hit;
                state_d = tmo_hit ? FIN : WAIT_M;
            end
            STORE: begin
                if (step_q != '0 && !edge_found_q && ((prev_q >= THR) != (cur_q >= THR))) begin
                    edge_found_d = 1'b1;
                    edge_step_d  = step_q;
                    edge_dir_d   = cur_q >= THR;
                end
                prev_d  = cur_q;
                state_d = step_q == STEP_W'(NUM_STEPS - 1) ? FIN : SHIFT;
            end
            SHIFT: begin
                step_d  = step_q + 1'b1;
                state_d = WAIT_PS;
            end
            WAIT_PS: if (ps_done) begin
                settle_d = SW'(SETTLE_CYCLES - 1);
                state_d  = SETTLE;
            end else begin
                tmo_d   = tmo_inc;
                error_d = error_q | tmo_hit;
                state_d = tmo_hit ? FIN : WAIT_PS;
            end
            SETTLE: begin
                settle_d = settle_q == '0 ? settle_q : settle_q - 1'b1;
                state_d  = settle_q == '0 ? MEAS : SETTLE;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d       = state_d != IDLE && state_d != FIN;
        done_d       = state_d == FIN;
        ps_en_d      = state_d == SHIFT;
        meas_start_d = state_d == MEAS;
    end

    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            state_q      <= IDLE;
            step_q       <= '0;
            tmo_q        <= '0;
            settle_q     <= '0;
            cur_q        <= '0;
            prev_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            ps_en_q      <= 1'b0;
            meas_start_q <= 1'b0;
            edge_found_q <= 1'b0;
            edge_step_q  <= '0;
            edge_dir_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            tmo_q        <= tmo_d;
            settle_q     <= settle_d;
            cur_q        <= cur_d;
            prev_q       <= prev_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            ps_en_q      <= ps_en_d;
            meas_start_q <= meas_start_d;
            edge_found_q <= edge_found_d;
            edge_step_q  <= edge_step_d;
            edge_dir_q   <= edge_dir_d;
        end
    end

    always_ff @(posedge system_clk) begin
        if (state_q == STORE) mem[step_q] <= cur_q;
        rd_data_q <= system_rst ? '0 : mem[rd_addr];
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign ps_en      = ps_en_q;
    assign ps_incdec  = 1'b1;
    assign meas_start = meas_start_q;
    assign rd_data    = rd_data_q;
    assign edge_found = edge_found_q;
    assign edge_step  = edge_step_q;
    assign edge_dir   = edge_dir_q;
endmodule
